// File: rtl/key_filter.sv
// Push-button debouncer: 2-FF synchronizer feeding a 4-state filter FSM with a stability counter.
// Emits a one-cycle press pulse and a debounced level (1 = released, 0 = pressed).
module key_filter #(
  parameter int unsigned CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StFiltDn,
    StDown,
    StFiltUp
  } state_e;

  logic             sync1;
  logic             sync2;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
    end else begin
      key_flag <= 1'b0;
      case (state)
        StIdle: begin
          if (!sync2) begin
            state <= StFiltDn;
            cnt   <= '0;
          end
        end
        StFiltDn: begin
          if (sync2) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state     <= StDown;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b0;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StDown: begin
          if (sync2) begin
            state <= StFiltUp;
            cnt   <= '0;
          end
        end
        StFiltUp: begin
          // A low sample here is release bounce: fall back to pressed without a new flag.
          if (!sync2) begin
            state <= StDown;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state     <= StIdle;
            cnt       <= '0;
            key_state <= 1'b1;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

  flag_single_cycle: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    key_flag |=> !key_flag);

  cnt_bounded: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    cnt <= CntLast);

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with CNT_MAX = 4: directed scenarios plus random key activity,
// checked against a consecutive-sample model of the debounce rule.
module tb_key_filter;

  localparam int CNT_MAX = 4;

  logic sys_clk;
  logic sys_rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;

  int n_cmp;
  int n_fail;

  key_filter #(
    .CNT_MAX(CNT_MAX)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Model: the debounced level flips once the synchronized key has differed from it on
  // CNT_MAX+1 consecutive edges; a flip to pressed emits the flag.
  logic m_s1, m_s2, m_lvl, m_flag;
  int   m_run;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_s1   <= 1'b1;
      m_s2   <= 1'b1;
      m_lvl  <= 1'b1;
      m_flag <= 1'b0;
      m_run  <= 0;
    end else begin
      m_s1   <= key_in;
      m_s2   <= m_s1;
      m_flag <= 1'b0;
      if (m_s2 == m_lvl) begin
        m_run <= 0;
      end else if (m_run + 1 == CNT_MAX + 1) begin
        m_run  <= 0;
        m_lvl  <= m_s2;
        m_flag <= !m_s2;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  task automatic hold_key(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    logic exp_flag, exp_state;
    sys_rst_n = 1'b1;
    key_in    = 1'b0;
    #1 sys_rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (key_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_flag: got %b want 0", key_flag);
    end
    if (key_state !== 1'b1) begin
      n_fail++; $display("FAIL reset_async_state: got %b want 1", key_state);
    end
    @(negedge sys_clk);
    n_cmp += 2;
    if (key_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_held_flag: got %b want 0", key_flag);
    end
    if (key_state !== 1'b1) begin
      n_fail++; $display("FAIL reset_held_state: got %b want 1", key_state);
    end
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sys_clk);
      exp_flag  = (i == CNT_MAX + 3);
      exp_state = (i < CNT_MAX + 3);
      n_cmp += 3;
      if (key_flag !== exp_flag) begin
        n_fail++; $display("FAIL reset_release_flag cyc %0d: got %b want %b", i, key_flag, exp_flag);
      end
      if (key_state !== exp_state) begin
        n_fail++;
        $display("FAIL reset_release_state cyc %0d: got %b want %b", i, key_state, exp_state);
      end
      if (key_flag !== m_flag) begin
        n_fail++; $display("FAIL reset_release_model cyc %0d: got %b want %b", i, key_flag, m_flag);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_flag, exp_state;
    hold_key(1'b1, 10);
    n_cmp++;
    if (key_state !== 1'b1) begin
      n_fail++; $display("FAIL clean_pre_state: got %b want 1", key_state);
    end
    key_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge sys_clk);
      exp_flag  = (i == CNT_MAX + 3);
      exp_state = (i < CNT_MAX + 3);
      n_cmp += 3;
      if (key_flag !== exp_flag) begin
        n_fail++; $display("FAIL clean_flag cyc %0d: got %b want %b", i, key_flag, exp_flag);
      end
      if (key_state !== exp_state) begin
        n_fail++; $display("FAIL clean_state cyc %0d: got %b want %b", i, key_state, exp_state);
      end
      if (key_state !== m_lvl) begin
        n_fail++; $display("FAIL clean_model cyc %0d: got %b want %b", i, key_state, m_lvl);
      end
    end
  endtask

  task automatic test_bounce();
    logic exp_flag, exp_state;
    hold_key(1'b1, 10);
    for (int j = 0; j < 20; j++) begin
      if (j > 0) begin
        exp_flag  = (j == 4 + CNT_MAX + 3);
        exp_state = (j < 4 + CNT_MAX + 3);
        n_cmp += 3;
        if (key_flag !== exp_flag) begin
          n_fail++; $display("FAIL bounce_flag cyc %0d: got %b want %b", j, key_flag, exp_flag);
        end
        if (key_state !== exp_state) begin
          n_fail++; $display("FAIL bounce_state cyc %0d: got %b want %b", j, key_state, exp_state);
        end
        if (key_flag !== m_flag) begin
          n_fail++; $display("FAIL bounce_model cyc %0d: got %b want %b", j, key_flag, m_flag);
        end
      end
      key_in = (j < 5) ? logic'(j % 2) : 1'b0;
      if (j < 19) @(negedge sys_clk);
    end
  endtask

  task automatic test_glitch();
    hold_key(1'b1, 10);
    for (int j = 0; j < 15; j++) begin
      if (j > 0) begin
        n_cmp += 2;
        if (key_flag !== 1'b0) begin
          n_fail++; $display("FAIL glitch_flag cyc %0d: got %b want 0", j, key_flag);
        end
        if (key_state !== 1'b1) begin
          n_fail++; $display("FAIL glitch_state cyc %0d: got %b want 1", j, key_state);
        end
      end
      key_in = (j >= 3);
      if (j < 14) @(negedge sys_clk);
    end
  endtask

  task automatic test_release_bounce();
    logic exp_state;
    hold_key(1'b0, 10);
    for (int j = 0; j < 15; j++) begin
      if (j > 0) begin
        exp_state = (j >= 2 + CNT_MAX + 3);
        n_cmp += 3;
        if (key_flag !== 1'b0) begin
          n_fail++; $display("FAIL release_flag cyc %0d: got %b want 0", j, key_flag);
        end
        if (key_state !== exp_state) begin
          n_fail++; $display("FAIL release_state cyc %0d: got %b want %b", j, key_state, exp_state);
        end
        if (key_state !== m_lvl) begin
          n_fail++; $display("FAIL release_model cyc %0d: got %b want %b", j, key_state, m_lvl);
        end
      end
      key_in = (j != 1);
      if (j < 14) @(negedge sys_clk);
    end
  endtask

  task automatic test_reset_mid_filter();
    hold_key(1'b1, 10);
    hold_key(1'b0, 5);
    #1 sys_rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (key_flag !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flag: got %b want 0", key_flag);
    end
    if (key_state !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state: got %b want 1", key_state);
    end
    key_in = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sys_clk);
      n_cmp += 2;
      if (key_flag !== 1'b0) begin
        n_fail++; $display("FAIL midrst_after_flag cyc %0d: got %b want 0", i, key_flag);
      end
      if (key_state !== 1'b1) begin
        n_fail++; $display("FAIL midrst_after_state cyc %0d: got %b want 1", i, key_state);
      end
    end
  endtask

  task automatic test_random();
    logic prev_flag;
    int   len;
    prev_flag = 1'b0;
    for (int s = 0; s < 80; s++) begin
      key_in = logic'($urandom_range(0, 1));
      len    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12))
                                           : int'($urandom_range(1, 5));
      for (int c = 0; c < len; c++) begin
        @(negedge sys_clk);
        n_cmp += 3;
        if (key_flag !== m_flag) begin
          n_fail++; $display("FAIL random_flag seg %0d: got %b want %b", s, key_flag, m_flag);
        end
        if (key_state !== m_lvl) begin
          n_fail++; $display("FAIL random_state seg %0d: got %b want %b", s, key_state, m_lvl);
        end
        if (prev_flag && key_flag) begin
          n_fail++; $display("FAIL random_double_flag seg %0d: got %b want 0", s, key_flag);
        end
        prev_flag = key_flag;
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_release_bounce();
    test_reset_mid_filter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
